// File: rtl/grid_config_loader.sv
// grid_config_loader
//   Streams a configuration image into a neuromorphic core grid. It runs one
//   load per start request:
//     1. It pulses rst_model to the grid.
//     2. It writes NUM_AXONS token-controller entries to every core.
//     3. It writes NUM_NEURONS CSRAM entries to every core.
//   The grid slot OUTPUT_CORE holds the output bus, so it is skipped in both
//   passes.
//
//   Optional feature (macro GRID_CFG_CHECKSUM_EN):
//     The loader keeps an XOR accumulator over every accepted word. A TC word
//     contributes its TCW payload bits, zero-extended. After the last CSRAM
//     word, the loader expects one trailing checksum word. A mismatch sets the
//     sticky cfg_error flag. Without the macro there is no CHECK state and
//     cfg_error is tied to 0.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   start, abort       begin a load (honoured only in IDLE); cancel a load
//   cfg_data           configuration word stream
//   cfg_valid          word handshake, valid side
//   cfg_ready          word handshake, ready side
//   rst_model          one-cycle model reset pulse to the grid
//   tc_*               token-controller write bus (one-cycle valid pulse)
//   csram_*            CSRAM write bus (one-cycle valid pulse)
//   busy               high in every state except IDLE
//   done               one-cycle completion pulse
//   cfg_error          sticky checksum error

module grid_config_loader #(
  parameter int NUM_CORES        = 5,
  parameter int OUTPUT_CORE      = 4,
  parameter int NUM_AXONS        = 256,
  parameter int NUM_NEURONS      = 256,
  parameter int NUM_WEIGHTS      = 4,
  parameter int CSRAM_READ_WIDTH = 367,
  localparam int TCW = $clog2(NUM_WEIGHTS),
  localparam int AW  = $clog2(NUM_AXONS),
  localparam int NW  = $clog2(NUM_NEURONS),
  localparam int CW  = $clog2(NUM_CORES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [CSRAM_READ_WIDTH-1:0] cfg_data,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  output logic                        rst_model,
  output logic [TCW-1:0]              tc_data,
  output logic [AW-1:0]               tc_addr,
  output logic [CW-1:0]               tc_core_idx,
  output logic                        tc_valid,
  output logic [CSRAM_READ_WIDTH-1:0] csram_data,
  output logic [NW-1:0]               csram_addr,
  output logic [CW-1:0]               csram_core_idx,
  output logic                        csram_valid,
  output logic                        busy,
  output logic                        done,
  output logic                        cfg_error
);

  // One address counter serves both passes, so it is sized for the larger one.
  localparam int CNT_W = (AW > NW) ? AW : NW;

  localparam logic [CNT_W-1:0] TC_LAST  = CNT_W'(NUM_AXONS - 1);
  localparam logic [CNT_W-1:0] NEU_LAST = CNT_W'(NUM_NEURONS - 1);
  localparam logic [CW-1:0]    OUT_CORE = CW'(OUTPUT_CORE);

  // First and last configurable slots, with the output bus slot excluded.
  localparam logic [CW-1:0] FIRST_CORE = (OUTPUT_CORE == 0) ? CW'(1) : CW'(0);
  localparam logic [CW-1:0] LAST_CORE  = (OUTPUT_CORE == NUM_CORES - 1) ?
                                         CW'(NUM_CORES - 2) : CW'(NUM_CORES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RST_MODEL,
    LOAD_TC,
    LOAD_CSRAM,
`ifdef GRID_CFG_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     core_reg, core_next;
  logic [CNT_W-1:0]  addr_reg, addr_next;
  logic [CW-1:0]     core_inc;
  logic              xfer;

  logic                        tc_valid_reg;
  logic [TCW-1:0]              tc_data_reg;
  logic [AW-1:0]               tc_addr_reg;
  logic [CW-1:0]               tc_core_reg;
  logic                        csram_valid_reg;
  logic [CSRAM_READ_WIDTH-1:0] csram_data_reg;
  logic [NW-1:0]               csram_addr_reg;
  logic [CW-1:0]               csram_core_reg;

  // Abort wins over a word presented in the same cycle. The word is not
  // written and no counter moves.
  assign xfer = cfg_valid && cfg_ready && !abort;

  // Next configurable core. Skip the output bus slot.
  always_comb begin
    core_inc = core_reg + CW'(1);
    if (core_inc == OUT_CORE) begin
      core_inc = core_reg + CW'(2);
    end
  end

  // State-decoded handshake and status outputs
  always_comb begin
    cfg_ready = 1'b0;
    case (state_reg)
      LOAD_TC, LOAD_CSRAM: cfg_ready = 1'b1;
`ifdef GRID_CFG_CHECKSUM_EN
      CHECK:               cfg_ready = 1'b1;
`endif
      default:             cfg_ready = 1'b0;
    endcase
  end

  assign rst_model = (state_reg == RST_MODEL);
  assign done      = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);

  // Next-state and counter logic
  always_comb begin
    state_next = state_reg;
    core_next  = core_reg;
    addr_next  = addr_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = RST_MODEL;
      end
      RST_MODEL: begin
        core_next  = FIRST_CORE;
        addr_next  = '0;
        state_next = LOAD_TC;
      end
      LOAD_TC: begin
        if (xfer) begin
          if (addr_reg == TC_LAST) begin
            addr_next = '0;
            if (core_reg == LAST_CORE) begin
              core_next  = FIRST_CORE;
              state_next = LOAD_CSRAM;
            end else begin
              core_next = core_inc;
            end
          end else begin
            addr_next = addr_reg + CNT_W'(1);
          end
        end
      end
      LOAD_CSRAM: begin
        if (xfer) begin
          if (addr_reg == NEU_LAST) begin
            addr_next = '0;
            if (core_reg == LAST_CORE) begin
              core_next = FIRST_CORE;
`ifdef GRID_CFG_CHECKSUM_EN
              state_next = CHECK;
`else
              state_next = DONE;
`endif
            end else begin
              core_next = core_inc;
            end
          end else begin
            addr_next = addr_reg + CNT_W'(1);
          end
        end
      end
`ifdef GRID_CFG_CHECKSUM_EN
      CHECK: begin
        if (xfer) state_next = DONE;
      end
`endif
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (abort && (state_reg != IDLE)) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      core_reg  <= '0;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      core_reg  <= core_next;
      addr_reg  <= addr_next;
    end
  end

  // Registered write buses. Each accepted word is written in the following
  // cycle, tagged with the counter values at the moment of transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc_valid_reg    <= 1'b0;
      tc_data_reg     <= '0;
      tc_addr_reg     <= '0;
      tc_core_reg     <= '0;
      csram_valid_reg <= 1'b0;
      csram_data_reg  <= '0;
      csram_addr_reg  <= '0;
      csram_core_reg  <= '0;
    end else begin
      tc_valid_reg    <= xfer && (state_reg == LOAD_TC);
      csram_valid_reg <= xfer && (state_reg == LOAD_CSRAM);
      if (xfer && (state_reg == LOAD_TC)) begin
        tc_data_reg <= cfg_data[TCW-1:0];
        tc_addr_reg <= addr_reg[AW-1:0];
        tc_core_reg <= core_reg;
      end
      if (xfer && (state_reg == LOAD_CSRAM)) begin
        csram_data_reg <= cfg_data;
        csram_addr_reg <= addr_reg[NW-1:0];
        csram_core_reg <= core_reg;
      end
    end
  end

  assign tc_valid       = tc_valid_reg;
  assign tc_data        = tc_data_reg;
  assign tc_addr        = tc_addr_reg;
  assign tc_core_idx    = tc_core_reg;
  assign csram_valid    = csram_valid_reg;
  assign csram_data     = csram_data_reg;
  assign csram_addr     = csram_addr_reg;
  assign csram_core_idx = csram_core_reg;

`ifdef GRID_CFG_CHECKSUM_EN
  logic [CSRAM_READ_WIDTH-1:0] chk_reg;
  logic                        cfg_error_reg;

  // cfg_error is sticky. Only rst_n clears it, not a later good load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_reg       <= '0;
      cfg_error_reg <= 1'b0;
    end else begin
      case (state_reg)
        RST_MODEL: chk_reg <= '0;
        LOAD_TC: begin
          if (xfer) begin
            chk_reg <= chk_reg ^
                       {{(CSRAM_READ_WIDTH-TCW){1'b0}}, cfg_data[TCW-1:0]};
          end
        end
        LOAD_CSRAM: begin
          if (xfer) chk_reg <= chk_reg ^ cfg_data;
        end
        CHECK: begin
          if (xfer && (cfg_data != chk_reg)) cfg_error_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cfg_error = cfg_error_reg;
`else
  assign cfg_error = 1'b0;
`endif

endmodule

// File: tb/tb_grid_config_loader.sv
module tb_grid_config_loader;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  cfg_data = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic          rst_model;
  logic [1:0]    tc_data;
  logic [1:0]    tc_addr;
  logic [1:0]    tc_core_idx;
  logic          tc_valid;
  logic [W-1:0]  csram_data;
  logic [1:0]    csram_addr;
  logic [1:0]    csram_core_idx;
  logic          csram_valid;
  logic          busy;
  logic          done;
  logic          cfg_error;

  grid_config_loader #(
    .NUM_CORES(3), .OUTPUT_CORE(1), .NUM_AXONS(4), .NUM_NEURONS(4),
    .NUM_WEIGHTS(4), .CSRAM_READ_WIDTH(W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .rst_model(rst_model),
    .tc_data(tc_data), .tc_addr(tc_addr), .tc_core_idx(tc_core_idx), .tc_valid(tc_valid),
    .csram_data(csram_data), .csram_addr(csram_addr), .csram_core_idx(csram_core_idx),
    .csram_valid(csram_valid),
    .busy(busy), .done(done), .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           csr;
    int           core;
    int           addr;
    logic [W-1:0] data;
    int           cyc;
  } wr_t;

  wr_t log_q[$];
  int  hs_q[$];
  int  n_rst, n_done, n_both, n_outcore;
  int  n_checks = 0;
  int  n_fail = 0;
  wr_t mon_w;

  // Write monitor; one line per observed write transaction.
  always @(negedge clk) begin
    if (tc_valid) begin
      mon_w.csr = 1'b0; mon_w.core = int'(tc_core_idx); mon_w.addr = int'(tc_addr);
      mon_w.data = W'(tc_data); mon_w.cyc = cyc;
      log_q.push_back(mon_w);
      $display("[%0d] tc write    core=%0d addr=%0d data=%h", cyc, tc_core_idx, tc_addr, tc_data);
    end
    if (csram_valid) begin
      mon_w.csr = 1'b1; mon_w.core = int'(csram_core_idx); mon_w.addr = int'(csram_addr);
      mon_w.data = csram_data; mon_w.cyc = cyc;
      log_q.push_back(mon_w);
      $display("[%0d] csram write core=%0d addr=%0d data=%h", cyc, csram_core_idx, csram_addr, csram_data);
    end
    if (tc_valid && csram_valid) n_both++;
    if ((tc_valid && tc_core_idx == 2'd1) || (csram_valid && csram_core_idx == 2'd1)) n_outcore++;
    if (rst_model) n_rst++;
    if (done) n_done++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] word_k(input int k);
    logic [7:0] lo;
    lo = 8'(k * 3 + 1);
    return {16'hC0DE, 8'(k), lo};
  endfunction

  function automatic logic [W-1:0] calc_chk();
    logic [W-1:0] acc;
    logic [W-1:0] w;
    acc = '0;
    for (int k = 0; k < 16; k++) begin
      w = word_k(k);
      if (k < 8) acc = acc ^ {30'd0, w[1:0]};
      else       acc = acc ^ w;
    end
    return acc;
  endfunction

  task automatic clear_log();
    log_q.delete();
    hs_q.delete();
    n_rst = 0; n_done = 0; n_both = 0; n_outcore = 0;
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send_word(input logic [W-1:0] d);
    int t;
    cfg_data  = d;
    cfg_valid = 1'b1;
    t = 0;
    while (!cfg_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check_eq("hs_timeout", 1, 0);
    hs_q.push_back(cyc);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input int gap, input bit poke_start, input bit good_chk);
    int t;
    logic [W-1:0] c;
    clear_log();
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      if (poke_start && (k == 3 || k == 11)) start = 1'b1;
      send_word(word_k(k));
      start = 1'b0;
      if (gap > 0) repeat (gap) @(negedge clk);
    end
`ifdef GRID_CFG_CHECKSUM_EN
    c = calc_chk();
    send_word(good_chk ? c : (c ^ 32'h1));
`else
    c = '0;
    if (good_chk) c = '1;
`endif
    t = 0;
    while (n_done == 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check_eq("done_count", n_done, 1);
    check_eq("busy_after_done", busy, 0);
  endtask

  task automatic verify_log(input string tag, input bit with_lat);
    logic [W-1:0] w;
    int n;
    check_eq({tag, "_nwrites"}, log_q.size(), 16);
    check_eq({tag, "_rst_pulses"}, n_rst, 1);
    check_eq({tag, "_both_valid"}, n_both, 0);
    check_eq({tag, "_outcore_wr"}, n_outcore, 0);
    n = (log_q.size() < 16) ? log_q.size() : 16;
    for (int k = 0; k < n; k++) begin
      w = word_k(k);
      check_eq($sformatf("%s_kind%0d", tag, k), log_q[k].csr, (k >= 8));
      check_eq($sformatf("%s_core%0d", tag, k), log_q[k].core, ((k % 8) < 4) ? 0 : 2);
      check_eq($sformatf("%s_addr%0d", tag, k), log_q[k].addr, k % 4);
      check_eq($sformatf("%s_data%0d", tag, k), log_q[k].data,
               (k < 8) ? {30'd0, w[1:0]} : w);
      if (with_lat && k < hs_q.size())
        check_eq($sformatf("%s_lat%0d", tag, k), log_q[k].cyc, hs_q[k] + 1);
    end
  endtask

  initial begin
    int base;
    clear_log();

    // Reset state
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", cfg_ready, 0);
    check_eq("rst_tc_valid", tc_valid, 0);
    check_eq("rst_csram_valid", csram_valid, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_rst_model", rst_model, 0);
    check_eq("rst_cfg_error", cfg_error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("release_no_pulses", n_rst + n_done + log_q.size(), 0);

    // Back-to-back load
    run_load(0, 1'b0, 1'b1);
    verify_log("b2b", 1'b1);
    check_eq("b2b_cfg_error", cfg_error, 0);

    // cfg_valid every other cycle, with start poked mid-load (must be ignored)
    run_load(1, 1'b1, 1'b1);
    verify_log("gap", 1'b1);

    // Abort after the fifth word, then a clean reload
    clear_log();
    pulse_start();
    for (int k = 0; k < 5; k++) send_word(word_k(k));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_ready", cfg_ready, 0);
    repeat (3) @(negedge clk);
    check_eq("abort_nwrites", log_q.size(), 5);
    check_eq("abort_no_done", n_done, 0);
    run_load(0, 1'b0, 1'b1);
    verify_log("reload", 1'b0);

`ifdef GRID_CFG_CHECKSUM_EN
    // A bad trailing word sets cfg_error; a later good load leaves it set.
    run_load(0, 1'b0, 1'b0);
    check_eq("chk_bad_err", cfg_error, 1);
    run_load(0, 1'b0, 1'b1);
    check_eq("chk_err_sticky", cfg_error, 1);
`else
    check_eq("no_chk_err", cfg_error, 0);
`endif

    // Reset while in LOAD_CSRAM
    clear_log();
    pulse_start();
    for (int k = 0; k < 10; k++) send_word(word_k(k));
    check_eq("pre_rst_csram_valid", csram_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_ready", cfg_ready, 0);
    check_eq("arst_csram_valid", csram_valid, 0);
    check_eq("arst_csram_data", csram_data, 0);
    check_eq("arst_csram_addr", csram_addr, 0);
    check_eq("arst_csram_core", csram_core_idx, 0);
    check_eq("arst_tc_data", tc_data, 0);
    check_eq("arst_tc_core", tc_core_idx, 0);
    check_eq("arst_cfg_error", cfg_error, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = log_q.size();
    n_rst = 0; n_done = 0;
    repeat (6) @(negedge clk);
    check_eq("post_rst_writes", log_q.size(), base);
    check_eq("post_rst_pulses", n_rst + n_done, 0);
    check_eq("post_rst_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
